// File: rtl/oled_spi_rx.sv
// SPI receiver for an OLED command/data stream: assembles bytes, decodes page/column
// addressing commands and writes display data into a 4-page x 128-column frame buffer.
module oled_spi_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned COLS        = 128
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CS,
  input  logic       SCLK,
  input  logic       SDO,
  input  logic       DC,
  output logic       BYTE_VLD,
  output logic [7:0] BYTE_DATA,
  output logic       BYTE_DC,
  output logic [1:0] PAGE,
  output logic [6:0] COL,
  input  logic [8:0] FB_RADDR,
  output logic [7:0] FB_RDATA,
  output logic       FRAME_ERR
);

  localparam int unsigned COL_W    = 7;
  localparam int unsigned FB_DEPTH = 512;

  typedef enum logic {
    ST_CMD,
    ST_PAGE_ARG
  } state_t;

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] sdo_sync;
  logic [SYNC_STAGES-1:0] dc_sync;
  logic                   cs_s;
  logic                   sclk_s;
  logic                   sdo_s;
  logic                   dc_s;
  logic                   cs_prev;
  logic                   sclk_prev;
  logic                   sclk_rise_c;
  logic                   cs_rise_c;
  logic [6:0]             shift_q;
  logic [2:0]             bit_cnt;

  state_t                 state_q;
  state_t                 state_d;
  logic [1:0]             page_d;
  logic [COL_W-1:0]       col_d;
  logic                   fb_we_c;

  logic [7:0]             fb_mem [FB_DEPTH];

  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign sdo_s  = sdo_sync[SYNC_STAGES-1];
  assign dc_s   = dc_sync[SYNC_STAGES-1];

  assign sclk_rise_c = sclk_s && !sclk_prev && !cs_s;
  assign cs_rise_c   = cs_s && !cs_prev;

  // Input synchronizers and edge history
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cs_sync   <= '0;
      sclk_sync <= '0;
      sdo_sync  <= '0;
      dc_sync   <= '0;
      cs_prev   <= 1'b0;
      sclk_prev <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      sdo_sync  <= {sdo_sync[SYNC_STAGES-2:0], SDO};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], DC};
      cs_prev   <= cs_s;
      sclk_prev <= sclk_s;
    end
  end

  // Bit assembly; the eighth bit goes straight into BYTE_DATA with the first seven
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shift_q   <= '0;
      bit_cnt   <= '0;
      BYTE_VLD  <= 1'b0;
      BYTE_DATA <= '0;
      BYTE_DC   <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      BYTE_VLD <= 1'b0;
      if (cs_s) begin
        bit_cnt <= '0;
      end else if (sclk_rise_c) begin
        shift_q <= {shift_q[5:0], sdo_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          BYTE_DATA <= {shift_q, sdo_s};
          BYTE_DC   <= dc_s;
          BYTE_VLD  <= 1'b1;
        end
      end
      if (cs_rise_c && (bit_cnt != 3'd0)) begin
        FRAME_ERR <= 1'b1;
      end
    end
  end

  // Decoder state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_CMD;
      PAGE    <= '0;
      COL     <= '0;
    end else begin
      state_q <= state_d;
      PAGE    <= page_d;
      COL     <= col_d;
    end
  end

  // Decoder next state: addressing commands and data-byte column advance
  always_comb begin
    state_d = state_q;
    page_d  = PAGE;
    col_d   = COL;
    fb_we_c = 1'b0;
    if (BYTE_VLD) begin
      if (BYTE_DC) begin
        fb_we_c = 1'b1;
        col_d   = (COL == COL_W'(COLS - 1)) ? '0 : COL + 7'd1;
        state_d = ST_CMD;
      end else begin
        case (state_q)
          ST_CMD: begin
            if (BYTE_DATA == 8'h22) begin
              state_d = ST_PAGE_ARG;
            end else if (BYTE_DATA[7:4] == 4'h0) begin
              col_d[3:0] = BYTE_DATA[3:0];
            end else if (BYTE_DATA[7:3] == 5'b00010) begin
              col_d[6:4] = BYTE_DATA[2:0];
            end
          end
          ST_PAGE_ARG: begin
            page_d  = BYTE_DATA[1:0];
            state_d = ST_CMD;
          end
          default: state_d = ST_CMD;
        endcase
      end
    end
  end

  // Frame buffer: read-before-write on address collision, contents never reset
  always_ff @(posedge CLK) begin
    if (fb_we_c) begin
      fb_mem[{PAGE, COL}] <= BYTE_DATA;
    end
    FB_RDATA <= fb_mem[FB_RADDR];
  end

endmodule

// File: doc/oled_spi_rx.md
OLED_SPI_RX -- requirements
Module: oled_spi_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth on CS/SCLK/SDO/DC inputs (valid range 2..3).
REQ-002 SHALL have parameter COLS, default 128, giving the columns per page; the column counter width is 7 bits.
REQ-003 SHALL have port CLK  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous assertion, active-low.
REQ-005 SHALL have port CS  input  1  SPI chip select from the OLED master, active-low.
REQ-006 SHALL have port SCLK  input  1  SPI clock; idles high; data sampled on its rising edge.
REQ-007 SHALL have port SDO  input  1  SPI serial data from the master, MSB first.
REQ-008 SHALL have port DC  input  1  0 = command byte, 1 = display-data byte.
REQ-009 SHALL have port BYTE_VLD  output  1  one-CLK pulse per completed byte.
REQ-010 SHALL have port BYTE_DATA  output  8  last completed byte, held until the next byte.
REQ-011 SHALL have port BYTE_DC  output  1  DC value captured with BYTE_DATA.
REQ-012 SHALL have port PAGE  output  2  current page pointer.
REQ-013 SHALL have port COL  output  7  current column pointer.
REQ-014 SHALL have port FB_RADDR  input  9  frame-buffer read address {page, col}.
REQ-015 SHALL have port FB_RDATA  output  8  frame-buffer read data, registered, 1-cycle latency.
REQ-016 SHALL have port FRAME_ERR  output  1  sticky flag: CS deasserted mid-byte.

Function
REQ-017 SHALL pass CS, SCLK, SDO and DC through SYNC_STAGES flops before use; SCLK rising edge = synchronized SCLK 0->1 while synchronized CS = 0.
REQ-018 SHALL require SCLK high and low phases of at least 2 CLK periods each; behaviour is unspecified otherwise.
REQ-019 SHALL shift synchronized SDO into an 8-bit shift register MSB first on each detected rising edge, with a 3-bit bit counter.
REQ-020 SHALL, on the 8th bit, capture the byte and the synchronized DC, and assert BYTE_VLD in the following CLK cycle for exactly one cycle.
REQ-021 SHALL, when synchronized CS rises with bit counter != 0, discard the partial byte, clear the bit counter, set FRAME_ERR, and emit no BYTE_VLD.
REQ-022 SHALL clear the bit counter whenever synchronized CS = 1; decoder state persists across CS deassertion between bytes.
REQ-023 SHALL decode using a state machine with states CMD and PAGE_ARG; reset state is CMD.
REQ-024 SHALL in CMD, for a command byte 0x22, go to PAGE_ARG with no other effect.
REQ-025 SHALL in PAGE_ARG, for a command byte b, set PAGE <= b[1:0] and return to CMD.
REQ-026 SHALL in CMD, for command 0x00-0x0F, set COL[3:0] <= b[3:0]; for 0x10-0x17, set COL[6:4] <= b[2:0]; for any other command, make no state change.
REQ-027 SHALL, for a data byte (DC=1) in either state, write the byte to the frame buffer at {PAGE, COL} in the BYTE_VLD cycle, then increment COL; COL = COLS-1 wraps to 0 with PAGE unchanged.
REQ-028 SHALL, for a data byte received in PAGE_ARG, also return the state machine to CMD (pending page argument cancelled).
REQ-029 SHALL update PAGE/COL in the BYTE_VLD cycle, so the new values are visible the next cycle.
REQ-030 SHALL implement the frame buffer as 512 x 8 (4 pages x 128 columns) with one write port (internal) and one read port (FB_RADDR/FB_RDATA); a simultaneous read and write to the same address returns the old data.

Reset
REQ-031 SHALL on RST=0 asynchronously clear synchronizers, shift register, bit counter, BYTE_VLD, BYTE_DATA, BYTE_DC, PAGE, COL and FRAME_ERR to 0 and the state machine to CMD; reset mid-byte drops that byte.
REQ-032 SHALL NOT reset frame-buffer contents or FB_RDATA; the bench writes before reading.
REQ-033 SHALL release reset synchronously to CLK (external synchronizer); the first edge is detected no earlier than SYNC_STAGES+1 cycles after release.

Verification
REQ-034 SHALL cover: RST=0 mid-activity -> all REQ-031 outputs 0 immediately; RST release, SCLK idle -> no BYTE_VLD.
REQ-035 SHALL cover: commands 0x22, 0x02, 0x00, 0x10, then data 0x41 -> four command BYTE_VLD pulses, PAGE=2, COL=0; after the data byte, FB_RADDR=256 reads 0x41 and COL=1.
REQ-036 SHALL cover: commands 0x0F, 0x17 (COL=127) on PAGE=1, then data 0xAA, 0x55 -> address 255 = 0xAA, address 128 = 0x55, COL=1, PAGE=1.
REQ-037 SHALL cover: CS high after 5 bits -> no BYTE_VLD, FRAME_ERR=1; the next full byte 0x3C is received correctly and FRAME_ERR stays 1.
REQ-038 SHALL cover: command 0x22 then data 0x7E -> state returns to CMD, PAGE unchanged, 0x7E written; command 0xAF -> PAGE/COL unchanged.
REQ-039 SHALL cover: CS toggled high between 0x22 and 0x03 -> PAGE=3.
